// File: rtl/ysyx_24110015_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding, reset PC,
// NOP instruction, error cause codes and the AXI read response code for OKAY.
package ysyx_24110015_fetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_IDLE  = 3'd4
  } fetch_state_e;

  localparam int unsigned CNT_W        = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUS      = 2'b10;
  localparam logic [1:0] RRESP_OKAY     = 2'b00;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24110015_perf_counter.sv
// Free-running wrapping event counter with increment enable and synchronous
// active-low clear.
module ysyx_24110015_perf_counter
  import ysyx_24110015_fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!clr_n_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_24110015_fetch_unit.sv
// Multi-cycle single-issue fetch stage: owns the PC, fetches one instruction
// per retire over an AXI4-Lite-style read channel and hands it to decode.
//
// state | meaning
// BOOT  | one quiet bus cycle after reset release
// REQ   | read address phase (or misaligned-PC fault, no bus access)
// WAIT  | waiting for read data beat
// VALID | {inst, pc_o, fetch_err, err_cause} offered to decode
// IDLE  | instruction consumed, waiting for next PC from write-back
module ysyx_24110015_fetch_unit
  import ysyx_24110015_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dnpc_valid,
  input  logic [31:0] dnpc,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic [31:0] pc_o,
  output logic        fetch_err,
  output logic [1:0]  err_cause,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic         pend_vld_q, pend_vld_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc_o_q, pc_o_d;
  logic         err_q, err_d;
  logic [1:0]   cause_q, cause_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      inst_q     <= NOP_INST;
      pc_o_q     <= RESET_PC;
      err_q      <= 1'b0;
      cause_q    <= CAUSE_NONE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      inst_q     <= inst_d;
      pc_o_q     <= pc_o_d;
      err_q      <= err_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    inst_d     = inst_q;
    pc_o_d     = pc_o_q;
    err_d      = err_q;
    cause_d    = cause_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        if (pc_misaligned(pc_q)) begin
          inst_d  = NOP_INST;
          pc_o_d  = pc_q;
          err_d   = 1'b1;
          cause_d = CAUSE_MISALIGN;
          state_d = ST_VALID;
        end else if (arready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rvalid) begin
          pc_o_d = pc_q;
          if (rresp != RRESP_OKAY) begin
            inst_d  = NOP_INST;
            err_d   = 1'b1;
            cause_d = CAUSE_BUS;
          end else begin
            inst_d = rdata;
          end
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (out_ready) begin
          // A strobe arriving with the accept is newer than anything pending.
          if (dnpc_valid || pend_vld_q) begin
            pc_d       = dnpc_valid ? dnpc : pend_q;
            pend_vld_d = 1'b0;
            err_d      = 1'b0;
            cause_d    = CAUSE_NONE;
            state_d    = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (dnpc_valid) begin
          pend_d     = dnpc;
          pend_vld_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (dnpc_valid || pend_vld_q) begin
          pc_d       = dnpc_valid ? dnpc : pend_q;
          pend_vld_d = 1'b0;
          err_d      = 1'b0;
          cause_d    = CAUSE_NONE;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign arvalid   = (state_q == ST_REQ) && !pc_misaligned(pc_q);
  assign araddr    = pc_q;
  assign rready    = (state_q == ST_WAIT);
  assign out_valid = (state_q == ST_VALID);
  assign inst      = inst_q;
  assign pc_o      = pc_o_q;
  assign fetch_err = err_q;
  assign err_cause = cause_q;

  logic fetch_inc, wait_inc;
  assign fetch_inc = (state_d == ST_VALID) && (state_q != ST_VALID);
  assign wait_inc  = (state_q == ST_REQ) || (state_q == ST_WAIT);

  ysyx_24110015_perf_counter u_fetch_cnt (
    .clk     (clk),
    .clr_n_i (rst),
    .inc_i   (fetch_inc),
    .cnt_o   (perf_fetch_cnt)
  );

  ysyx_24110015_perf_counter u_wait_cnt (
    .clk     (clk),
    .clr_n_i (rst),
    .inc_i   (wait_inc),
    .cnt_o   (perf_wait_cnt)
  );

`ifndef SYNTHESIS
  // Write-back may only hand over a next PC once the current instruction is out.
  a_dnpc_in_busy_state : assert property (@(posedge clk) disable iff (!rst)
    dnpc_valid |-> (state_q == ST_VALID || state_q == ST_IDLE));
`endif

endmodule

// File: tb/tb_ysyx_24110015_fetch_unit.sv
// Scoreboard bench for the fetch stage: directed bring-up cases followed by
// randomized next-PC traffic against a randomly stalling memory model.
module tb_ysyx_24110015_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dnpc_valid = 1'b0;
  logic [31:0] dnpc = '0;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] inst, pc_o;
  logic        fetch_err;
  logic [1:0]  err_cause;
  logic [31:0] perf_fetch_cnt, perf_wait_cnt;

  always #5 clk = ~clk;

  ysyx_24110015_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .dnpc_valid     (dnpc_valid),
    .dnpc           (dnpc),
    .arvalid        (arvalid),
    .arready        (arready),
    .araddr         (araddr),
    .rvalid         (rvalid),
    .rready         (rready),
    .rdata          (rdata),
    .rresp          (rresp),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .inst           (inst),
    .pc_o           (pc_o),
    .fetch_err      (fetch_err),
    .err_cause      (err_cause),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
    logic [1:0]  cause;
    logic [31:0] idx;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cmps = 0;
  int          errs = 0;
  logic [31:0] fetch_idx = '0;

  // Memory image and fault map of the modelled system.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_PC) return 32'h0010_0073;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic faulty(input logic [31:0] a);
    return a[11:8] == 4'h3;
  endfunction

  function automatic exp_t expect_for(input logic [31:0] a, input logic [31:0] idx);
    exp_t e;
    e.pc  = a;
    e.idx = idx;
    if (a[1:0] != 2'b00) begin
      e.inst = NOP; e.err = 1'b1; e.cause = 2'b01;
    end else if (faulty(a)) begin
      e.inst = NOP; e.err = 1'b1; e.cause = 2'b10;
    end else begin
      e.inst = mem_word(a); e.err = 1'b0; e.cause = 2'b00;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] a;
    int          r;
    a = $urandom & 32'hFFFF_FFFC;
    r = $urandom_range(0, 7);
    if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
    else if (r == 1) a[11:8] = 4'h3;
    else if (a[11:8] == 4'h3) a[8] = 1'b0;
    return a;
  endfunction

  // Memory slave with programmable (directed) or random per-beat stalls.
  int          ar_cnt = 0, r_cnt = 0;
  int          ar_dir = 0, r_dir = 0, ar_rnd = 0, r_rnd = 0;
  bit          rand_bus = 1'b0;
  logic [31:0] rd_addr = '0;

  assign arready = arvalid && (ar_cnt >= (rand_bus ? ar_rnd : ar_dir));
  assign rvalid  = rready && (r_cnt >= (rand_bus ? r_rnd : r_dir));
  assign rdata   = mem_word(rd_addr);
  assign rresp   = faulty(rd_addr) ? 2'b10 : 2'b00;

  always @(posedge clk) begin
    ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
    r_cnt  <= (rready && !rvalid) ? r_cnt + 1 : 0;
    if (arvalid && arready) begin
      rd_addr <= araddr;
      ar_rnd  <= $urandom_range(0, 3);
    end
    if (rready && rvalid) r_rnd <= $urandom_range(0, 3);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle decode sees out_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        cmps++;
        errs++;
        $display("FAIL sb_empty: out_valid with pc_o %h but nothing expected", pc_o);
      end else begin
        mon_e = sb[0];
        chk("inst", inst, mon_e.inst);
        chk("pc_o", pc_o, mon_e.pc);
        chk("fetch_err", {31'd0, fetch_err}, {31'd0, mon_e.err});
        chk("err_cause", {30'd0, err_cause}, {30'd0, mon_e.cause});
        chk("perf_fetch_cnt", perf_fetch_cnt, mon_e.idx);
        if (out_ready) mon_e = sb.pop_front();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] a);
    fetch_idx = fetch_idx + 1;
    sb.push_back(expect_for(a, fetch_idx));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic check_req(input logic [31:0] a);
    chk("req_arvalid", {31'd0, arvalid}, {31'd0, (a[1:0] == 2'b00)});
    if (a[1:0] == 2'b00) chk("req_araddr", araddr, a);
  endtask

  // Consume the instruction on offer and supply the next PC by one of three
  // routes: strobes while held (last one wins), strobe with accept, or IDLE strobe.
  task automatic handshake(input int hold, input bit s_hold, input logic [31:0] hold_pc,
                           input bit s_acc, input logic [31:0] acc_pc,
                           input int gap, input logic [31:0] idle_pc);
    logic [31:0] nxt;
    bit          have_pend;
    have_pend = 1'b0;
    wait_valid();
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      if (s_hold && (i == 0 || i == hold - 1)) begin
        dnpc_valid = 1'b1;
        dnpc       = (i == hold - 1) ? hold_pc : (hold_pc ^ 32'h0000_0100);
        have_pend  = 1'b1;
      end
      step();
      dnpc_valid = 1'b0;
    end
    out_ready = 1'b1;
    if (s_acc) begin
      dnpc_valid = 1'b1;
      dnpc       = acc_pc;
    end
    nxt = s_acc ? acc_pc : (have_pend ? hold_pc : idle_pc);
    if (s_acc || have_pend) push_fetch(nxt);
    step();
    out_ready  = 1'b0;
    dnpc_valid = 1'b0;
    dnpc       = $urandom;
    if (!(s_acc || have_pend)) begin
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_arvalid", {31'd0, arvalid}, 32'd0);
      repeat (gap) step();
      dnpc_valid = 1'b1;
      dnpc       = idle_pc;
      push_fetch(idle_pc);
      step();
      dnpc_valid = 1'b0;
    end
    check_req(nxt);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc_o", pc_o, RST_PC);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_err_cause", {30'd0, err_cause}, 32'd0);
    chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst_perf_wait", perf_wait_cnt, 32'd0);
    chk("rst_araddr", araddr, RST_PC);

    // Zero-wait bring-up: BOOT, REQ, WAIT, VALID.
    fetch_idx = '0;
    push_fetch(RST_PC);
    rst = 1'b1;
    chk("c1_arvalid", {31'd0, arvalid}, 32'd0);
    step();
    chk("c2_arvalid", {31'd0, arvalid}, 32'd1);
    chk("c2_araddr", araddr, RST_PC);
    step();
    chk("c3_rready", {31'd0, rready}, 32'd1);
    step();
    chk("c4_out_valid", {31'd0, out_valid}, 32'd1);
    chk("c4_inst", inst, 32'h0010_0073);
    chk("c4_perf_wait", perf_wait_cnt, 32'd2);

    handshake(4, 1'b1, 32'h8000_0004, 1'b0, 32'h0, 0, 32'h0);
    handshake(0, 1'b0, 32'h0, 1'b1, 32'h8000_0002, 0, 32'h0);
    handshake(2, 1'b0, 32'h0, 1'b1, 32'h8000_0300, 0, 32'h0);
    handshake(1, 1'b0, 32'h0, 1'b0, 32'h0, 2, 32'h8000_0008);

    // Reset while the data beat is outstanding.
    r_dir = 5;
    step();
    chk("pre_rst_rready", {31'd0, rready}, 32'd1);
    rst = 1'b0;
    sb.delete();
    step();
    chk("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("mid_rst_rready", {31'd0, rready}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_pc", araddr, RST_PC);
    chk("mid_rst_perf_wait", perf_wait_cnt, 32'd0);

    // Address phase stalled three cycles.
    r_dir  = 0;
    ar_dir = 3;
    fetch_idx = '0;
    push_fetch(RST_PC);
    rst = 1'b1;
    step();
    repeat (4) begin
      chk("hold_arvalid", {31'd0, arvalid}, 32'd1);
      chk("hold_araddr", araddr, RST_PC);
      step();
    end
    wait_valid();
    chk("stall_perf_wait", perf_wait_cnt, 32'd5);

    rand_bus = 1'b1;
    repeat (40) begin
      handshake($urandom_range(0, 3), 1'($urandom_range(0, 1)), rand_pc(),
                ($urandom_range(0, 2) == 0), rand_pc(),
                $urandom_range(0, 2), rand_pc());
    end
    wait_valid();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
